instruction_decoder_pipe: RTL

Parametrised, pipelined successor to the combinational mode decoder. It accepts instruction words over a valid/ready interface and decodes the top MODE_W bits into a one-hot mode vector plus a binary index. It also extracts the operand field, flags modes that are disabled by a runtime mask, and counts retired decodes. It sits between instruction fetch and the execution unit, with a 2-entry skid buffer so both sides can stall independently.

---
 rtl/instruction_decoder_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instruction_decoder_pipe.sv
// Purpose: decodes the mode field of an instruction word into one-hot + index, extracts operand, flags disabled modes, counts retired decodes.
// Latency: 1 cycle from accept to output when the output register is empty or firing.
// Backpressure: 2-entry skid (output reg + skid reg); in_ready is registered (~skid valid), never combinational on out_ready.
module instruction_decoder_pipe #(
  parameter int INSTR_W = 8,
  parameter int MODE_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        instruction,
  input  logic [(2**MODE_W)-1:0]    mode_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(2**MODE_W)-1:0]    mode,
  output logic [MODE_W-1:0]         mode_idx,
  output logic [INSTR_W-MODE_W-1:0] operand,
  output logic                      illegal,
  input  logic                      clear_count,
  output logic [CNT_W-1:0]          decode_count
);

  localparam int NMODE = 2**MODE_W;
  localparam int OP_W  = INSTR_W - MODE_W;

  typedef struct packed {
    logic [NMODE-1:0]  mode;
    logic [MODE_W-1:0] idx;
    logic [OP_W-1:0]   operand;
    logic              illegal;
  } entry_t;

  logic              or_vld_q, or_vld_d;
  entry_t            or_dat_q, or_dat_d;
  logic              sk_vld_q, sk_vld_d;
  entry_t            sk_dat_q, sk_dat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              fire;
  logic              or_free;
  logic [MODE_W-1:0] field;
  entry_t            dec;

  assign field   = instruction[INSTR_W-1 -: MODE_W];
  assign accept  = in_valid & ~sk_vld_q;
  assign fire    = or_vld_q & out_ready;
  assign or_free = ~or_vld_q | out_ready;

  // Decode the incoming word; the enable mask is frozen into the entry here.
  always_comb begin
    dec         = '0;
    dec.idx     = field;
    dec.operand = instruction[OP_W-1:0];
    dec.illegal = ~mode_en[field];
    for (int k = 0; k < NMODE; k++) begin
      dec.mode[k] = (field == MODE_W'(k)) & mode_en[k];
    end
  end

  // Two-entry FIFO steering: skid drains into the output register before new words.
  always_comb begin
    or_vld_d = or_vld_q;
    or_dat_d = or_dat_q;
    sk_vld_d = sk_vld_q;
    sk_dat_d = sk_dat_q;
    if (or_free) begin
      if (sk_vld_q) begin
        // in_ready is low while the skid is full, so no accept can collide here.
        or_vld_d = 1'b1;
        or_dat_d = sk_dat_q;
        sk_vld_d = 1'b0;
      end else if (accept) begin
        or_vld_d = 1'b1;
        or_dat_d = dec;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (accept) begin
      sk_vld_d = 1'b1;
      sk_dat_d = dec;
    end
  end

  // Retired-decode counter; clear wins over a simultaneous fire.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld_q <= 1'b0;
      or_dat_q <= '0;
      sk_vld_q <= 1'b0;
      sk_dat_q <= '0;
      cnt_q    <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      or_dat_q <= or_dat_d;
      sk_vld_q <= sk_vld_d;
      sk_dat_q <= sk_dat_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = ~sk_vld_q;
  assign out_valid    = or_vld_q;
  assign mode         = or_dat_q.mode;
  assign mode_idx     = or_dat_q.idx;
  assign operand      = or_dat_q.operand;
  assign illegal      = or_dat_q.illegal;
  assign decode_count = cnt_q;

endmodule
